// File: rtl/com_bus_arbiter_i.sv
// Round-robin owner selection for the instruction-side common bus, with a
// one-cycle turnaround between owners and a watchdog on stalled fills.
module com_bus_arbiter_i #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] Com_Bus_Req_proc,
  input  logic             Data_in_Bus,
  output logic [N_REQ-1:0] Com_Bus_Gnt_proc,
  output logic [1:0]       Gnt_id,
  output logic             Bus_busy,
  output logic             Arb_timeout
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [1:0]         gnt_id_q, gnt_id_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;

  logic               found;
  logic [1:0]         winner;
  logic [1:0]         idx;

  // Rotating priority search starting at rr_ptr; the first hit wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = 2'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found && Com_Bus_Req_proc[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE, TURN: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        busy_d   = 1'b0;
        state_d  = IDLE;
        if (found) begin
          state_d       = GRANT;
          gnt_d[winner] = 1'b1;
          gnt_id_d      = winner;
          busy_d        = 1'b1;
          hold_cnt_d    = '0;
          rr_ptr_d      = 2'((int'(winner) + 1) % N_REQ);
        end
      end
      GRANT: begin
        // The owner index doubles as the pointer into the request vector.
        if (!Com_Bus_Req_proc[gnt_id_q]) begin
          state_d  = TURN;
          gnt_d    = '0;
          gnt_id_d = '0;
          busy_d   = 1'b0;
        end else if (Data_in_Bus) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
          state_d   = TURN;
          gnt_d     = '0;
          gnt_id_d  = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign Com_Bus_Gnt_proc = gnt_q;
  assign Gnt_id           = gnt_id_q;
  assign Bus_busy         = busy_q;
  assign Arb_timeout      = timeout_q;

endmodule
